counter_7sd: RTL and testbench

- Single-digit up/down counter whose value drives a 7-segment display pattern directly.
- Supports pause (hold) and reverse (count down).
- A parameterised prescaler sets the count rate.
- Leaf block placed between the system clock domain and a display pin driver; one instance per display digit.

---
 rtl/counter_7sd_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 43 ++++
 rtl/counter_7sd.sv | 84 ++++++++
 tb/tb_counter_7sd.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_7sd_pkg.sv
// rtl/counter_7sd_pkg.sv - shared constants and helpers for the counter_7sd digit
//
// Purpose : digit width, wrap limits and 7-segment patterns ({g,f,e,d,c,b,a},
//           active-high) shared by counter_7sd and seg7_decode.
// Ports   : none (package).
package counter_7sd_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] MAX_DEC = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_HEX = 4'd15;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Highest legal digit value for the selected counting mode.
  function automatic logic [DIGIT_W-1:0] max_digit(input logic hex_en);
    return hex_en ? MAX_HEX : MAX_DEC;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit digit to 7-segment pattern lookup
//
// Purpose : maps a digit to its {g,f,e,d,c,b,a} active-high pattern.
//           With HEX_EN=0, codes 10..15 are not legal digits and decode blank.
// Ports   : digit [3:0] in  - registered digit value
//           data  [6:0] out - segment pattern
module seg7_decode
  import counter_7sd_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   data
);

  always_comb begin
    data = SEG_BLANK;
    unique case (digit)
      4'h0: data = SEG_0;
      4'h1: data = SEG_1;
      4'h2: data = SEG_2;
      4'h3: data = SEG_3;
      4'h4: data = SEG_4;
      4'h5: data = SEG_5;
      4'h6: data = SEG_6;
      4'h7: data = SEG_7;
      4'h8: data = SEG_8;
      4'h9: data = SEG_9;
      4'hA: data = SEG_A;
      4'hB: data = SEG_B;
      4'hC: data = SEG_C;
      4'hD: data = SEG_D;
      4'hE: data = SEG_E;
      4'hF: data = SEG_F;
      default: data = SEG_BLANK;
    endcase
    // In decimal mode a code above 9 can only come from a fault; show nothing.
    if (!HEX_EN && (digit > MAX_DEC)) begin
      data = SEG_BLANK;
    end
  end

endmodule

// File: rtl/counter_7sd.sv
// rtl/counter_7sd.sv - prescaled up/down single-digit counter with 7-segment output
//
// Purpose : one display digit; counts up or down once every PRESCALE unpaused
//           clocks and drives the segment pattern of the current digit.
// Config  : define COUNTER_7SD_HEX_MODE_EN to count 0..F instead of 0..9.
// Ports   : clock       in  - system clock, rising edge
//           reset       in  - asynchronous, active-low
//           pause       in  - 1 freezes digit and prescaler
//           reverse     in  - 0 count up, 1 count down (sampled on tick)
//           data  [6:0] out - segment pattern {g,f,e,d,c,b,a}, active-high
module counter_7sd
  import counter_7sd_pkg::*;
#(
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             reverse,
  output logic [SEG_W-1:0] data
);

`ifdef COUNTER_7SD_HEX_MODE_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam logic [DIGIT_W-1:0]    DIGIT_MAX    = max_digit(HEX_EN);
  localparam logic [PRESCALE_W-1:0] PRESCALE_TOP = PRESCALE_W'(PRESCALE - 1);

  logic [DIGIT_W-1:0]    digit;
  logic [DIGIT_W-1:0]    digit_next;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick;

  assign tick = !pause && (prescaler == PRESCALE_TOP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else if (!pause) begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Out-of-range digits (only reachable by fault) recover to the wrap target
  // of the current direction: 0 going up, DIGIT_MAX going down.
  always_comb begin
    digit_next = digit;
    if (reverse) begin
      if ((digit == '0) || (digit > DIGIT_MAX)) begin
        digit_next = DIGIT_MAX;
      end else begin
        digit_next = digit - 1'b1;
      end
    end else begin
      if (digit >= DIGIT_MAX) begin
        digit_next = '0;
      end else begin
        digit_next = digit + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (tick) begin
      digit <= digit_next;
    end
  end

  seg7_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .digit (digit),
    .data  (data)
  );

endmodule

// File: tb/tb_counter_7sd.sv
// tb/tb_counter_7sd.sv - directed self-checking bench for counter_7sd
module tb_counter_7sd;

  logic       clock = 1'b0;
  logic       reset;
  logic       pause;
  logic       reverse;
  logic [6:0] data;
  logic [6:0] data_p4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  counter_7sd #(.PRESCALE(1), .PRESCALE_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .pause   (pause),
    .reverse (reverse),
    .data    (data)
  );

  counter_7sd #(.PRESCALE(4), .PRESCALE_W(16)) dut_p4 (
    .clock   (clock),
    .reset   (reset),
    .pause   (pause),
    .reverse (reverse),
    .data    (data_p4)
  );

  task automatic edge_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    pause   = 1'b0;
    reverse = 1'b0;
    #1;
    tests_run++;
    if (data !== 7'h3F) begin
      tests_failed++;
      $display("FAIL reset_async data=%h expected=3f", data);
    end
    tests_run++;
    if (data_p4 !== 7'h3F) begin
      tests_failed++;
      $display("FAIL reset_async_p4 data=%h expected=3f", data_p4);
    end
    edge_step();
    edge_step();
    tests_run++;
    if (data !== 7'h3F) begin
      tests_failed++;
      $display("FAIL reset_hold data=%h expected=3f", data);
    end
    reset = 1'b1;
  endtask

  task automatic test_count_up();
    logic [6:0] exp_up [12];
`ifdef COUNTER_7SD_HEX_MODE_EN
    exp_up = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
               7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39};
`else
    exp_up = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
               7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h06, 7'h5B};
`endif
    for (int i = 0; i < 12; i++) begin
      edge_step();
      tests_run++;
      if (data !== exp_up[i]) begin
        tests_failed++;
        $display("FAIL count_up edge=%0d data=%h expected=%h", i + 1, data, exp_up[i]);
      end
    end
  endtask

  task automatic test_count_down();
    logic [6:0] exp_dn [3];
`ifdef COUNTER_7SD_HEX_MODE_EN
    exp_dn = '{7'h71, 7'h79, 7'h5E};
`else
    exp_dn = '{7'h6F, 7'h7F, 7'h07};
`endif
    do_reset();
    reverse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      tests_run++;
      if (data !== exp_dn[i]) begin
        tests_failed++;
        $display("FAIL count_down edge=%0d data=%h expected=%h", i + 1, data, exp_dn[i]);
      end
    end
    reverse = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    reverse = 1'b0;
    repeat (5) edge_step();
    tests_run++;
    if (data !== 7'h6D) begin
      tests_failed++;
      $display("FAIL pause_setup data=%h expected=6d", data);
    end
    pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      // Reverse toggling while paused must not matter.
      reverse = i[0];
      edge_step();
      tests_run++;
      if (data !== 7'h6D) begin
        tests_failed++;
        $display("FAIL pause_hold edge=%0d data=%h expected=6d", i + 1, data);
      end
    end
    reverse = 1'b0;
    pause   = 1'b0;
    edge_step();
    tests_run++;
    if (data !== 7'h7D) begin
      tests_failed++;
      $display("FAIL pause_release data=%h expected=7d", data);
    end
  endtask

  task automatic test_mid_reset();
    edge_step();
    tests_run++;
    if (data !== 7'h07) begin
      tests_failed++;
      $display("FAIL mid_reset_setup data=%h expected=07", data);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (data !== 7'h3F) begin
      tests_failed++;
      $display("FAIL mid_reset_async data=%h expected=3f", data);
    end
    @(negedge clock);
    reset = 1'b1;
    tests_run++;
    if (data !== 7'h3F) begin
      tests_failed++;
      $display("FAIL mid_reset_release data=%h expected=3f", data);
    end
    edge_step();
    tests_run++;
    if (data !== 7'h06) begin
      tests_failed++;
      $display("FAIL mid_reset_first_edge data=%h expected=06", data);
    end
  endtask

  task automatic test_prescale();
    logic [6:0] exp_p4 [8];
    exp_p4 = '{7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h06, 7'h06, 7'h06, 7'h5B};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      edge_step();
      tests_run++;
      if (data_p4 !== exp_p4[i]) begin
        tests_failed++;
        $display("FAIL prescale edge=%0d data=%h expected=%h", i + 1, data_p4, exp_p4[i]);
      end
    end
    // Phase is kept across a pause: 2 edges in, 3 paused, 1 more -> still 2.
    repeat (2) edge_step();
    pause = 1'b1;
    repeat (3) edge_step();
    pause = 1'b0;
    edge_step();
    tests_run++;
    if (data_p4 !== 7'h5B) begin
      tests_failed++;
      $display("FAIL prescale_phase_hold data=%h expected=5b", data_p4);
    end
    edge_step();
    tests_run++;
    if (data_p4 !== 7'h4F) begin
      tests_failed++;
      $display("FAIL prescale_phase_step data=%h expected=4f", data_p4);
    end
  endtask

`ifdef COUNTER_7SD_HEX_MODE_EN
  task automatic test_hex();
    logic [6:0] exp_hx [7];
    exp_hx = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};
    do_reset();
    repeat (9) edge_step();
    for (int i = 0; i < 7; i++) begin
      edge_step();
      tests_run++;
      if (data !== exp_hx[i]) begin
        tests_failed++;
        $display("FAIL hex_up step=%0d data=%h expected=%h", i + 1, data, exp_hx[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_mid_reset();
    test_prescale();
`ifdef COUNTER_7SD_HEX_MODE_EN
    test_hex();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
